// File: rtl/step_controller.sv
// step_controller: single-step / free-run clock-enable generator for a soft core.
//
// A debounced step key issues one cpu_ce strobe per press while stopped. A run
// switch selects free-running mode, where a programmable divider issues strobes
// periodically. An optional PC breakpoint halts free-running mode.
//
// Optional feature: define STEP_CTRL_BREAKPOINT_EN to compile in the breakpoint
// logic. Without it, bp_en/bp_addr/pc are ignored and HALT is unreachable.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   key_step_n  in   raw step pushbutton (active-low, bouncing)
//   run_sw      in   raw run switch (1 = free-running)
//   rate_sel    in   run-rate select: period = max(1, RUN_DIV >> (2*rate_sel))
//   bp_en       in   breakpoint enable
//   bp_addr     in   breakpoint address, compared against pc[7:0]
//   pc          in   current core PC
//   cpu_ce      out  one-cycle clock-enable strobe to the core
//   halted      out  high while in HALT
//   state       out  FSM state: IDLE=00, RUN=01, HALT=10
//   step_count  out  strobes issued since reset (wraps)
module step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned RUN_DIV         = 25000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        key_step_n,
  input  logic        run_sw,
  input  logic [1:0]  rate_sel,
  input  logic        bp_en,
  input  logic [7:0]  bp_addr,
  input  logic [31:0] pc,
  output logic        cpu_ce,
  output logic        halted,
  output logic [1:0]  state,
  output logic [15:0] step_count
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StHalt = 2'b10
  } state_e;

  localparam int unsigned         DbW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DbW-1:0]      DbLast = DbW'(DEBOUNCE_CYCLES - 1);

  // Synchronizers
  logic key_meta_q, key_sync_q, run_meta_q, run_sync_q;

  // Debouncer
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           key_lvl_q, key_lvl_d, key_prev_q;
  logic           press_ev;

  // Control
  state_e      state_q, state_d;
  logic [31:0] div_q, div_d;
  logic [1:0]  rate_q;
  logic        step_q, step_d;
  logic        run_ce;
  logic [15:0] step_cnt_q;
  logic [31:0] shifted, period_last;
  logic        rate_chg, bp_hit;

  // Debounce: count consecutive samples that disagree with the accepted level;
  // a sample that agrees restarts the count.
  always_comb begin
    db_cnt_d  = '0;
    key_lvl_d = key_lvl_q;
    if (key_sync_q != key_lvl_q) begin
      if (db_cnt_q == DbLast) key_lvl_d = key_sync_q;
      else                    db_cnt_d  = db_cnt_q + 1'b1;
    end
  end

  assign press_ev = key_prev_q & ~key_lvl_q;

  assign shifted     = 32'(RUN_DIV) >> {rate_sel, 1'b0};
  assign period_last = (shifted == 32'd0) ? 32'd0 : shifted - 32'd1;
  assign rate_chg    = (rate_sel != rate_q);

`ifdef STEP_CTRL_BREAKPOINT_EN
  assign bp_hit = bp_en && (pc[7:0] == bp_addr);
  assign halted = (state_q == StHalt);
  logic unused_pc_hi;
  assign unused_pc_hi = ^pc[31:8];
`else
  assign bp_hit = 1'b0;
  assign halted = 1'b0;
  logic unused_bp;
  assign unused_bp = ^{bp_en, bp_addr, pc};
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    step_d  = 1'b0;
    run_ce  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run_sync_q) begin
          state_d = StRun;
          div_d   = '0;
        end else begin
          step_d = press_ev;
        end
      end
      StRun: begin
        if (!run_sync_q) begin
          state_d = StIdle;
          div_d   = '0;
        end else if (rate_chg && (div_q >= period_last)) begin
          // Shortened period already passed: restart without a strobe.
          div_d = '0;
        end else if (div_q == period_last) begin
          div_d = '0;
          if (bp_hit) state_d = StHalt;
          else        run_ce  = 1'b1;
        end else begin
          div_d = div_q + 32'd1;
        end
      end
      StHalt: begin
        if (!run_sync_q) state_d = StIdle;
        else             step_d  = press_ev;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
      run_meta_q <= 1'b0;
      run_sync_q <= 1'b0;
      db_cnt_q   <= '0;
      key_lvl_q  <= 1'b1;
      key_prev_q <= 1'b1;
      state_q    <= StIdle;
      div_q      <= '0;
      rate_q     <= 2'b00;
      step_q     <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      key_meta_q <= key_step_n;
      key_sync_q <= key_meta_q;
      run_meta_q <= run_sw;
      run_sync_q <= run_meta_q;
      db_cnt_q   <= db_cnt_d;
      key_lvl_q  <= key_lvl_d;
      key_prev_q <= key_lvl_q;
      state_q    <= state_d;
      div_q      <= div_d;
      rate_q     <= rate_sel;
      step_q     <= step_d;
      if (cpu_ce) step_cnt_q <= step_cnt_q + 16'd1;
    end
  end

  assign cpu_ce     = run_ce | step_q;
  assign state      = state_q;
  assign step_count = step_cnt_q;

endmodule

// File: tb/tb_step_controller.sv
module tb_step_controller;

  logic        clk;
  logic        reset_n;
  logic        key_step_n;
  logic        run_sw;
  logic [1:0]  rate_sel;
  logic        bp_en;
  logic [7:0]  bp_addr;
  logic [31:0] pc;
  logic        cpu_ce;
  logic        halted;
  logic [1:0]  state;
  logic [15:0] step_count;

  step_controller #(
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV        (64)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_step_n(key_step_n),
    .run_sw    (run_sw),
    .rate_sel  (rate_sel),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .pc        (pc),
    .cpu_ce    (cpu_ce),
    .halted    (halted),
    .state     (state),
    .step_count(step_count)
  );

  int          cyc;
  int          exp_q[$];
  int          obs_q[$];
  int          n_tests;
  int          n_fail;
  logic [15:0] exp_count;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: each strobe executes one instruction
  always @(posedge clk) if (cpu_ce === 1'b1) pc <= pc + 32'd4;

  // Record the cycle of every observed strobe
  always @(negedge clk) begin
    #1;
    if (cpu_ce === 1'b1) obs_q.push_back(cyc);
  end

  // Expected run strobes: divider reaches period-1 every period cycles
  task automatic push_run(input int first, input int period, input int last);
    for (int t = first; t <= last; t += period) begin
      exp_q.push_back(t);
      exp_count = exp_count + 16'd1;
    end
  endtask

  // Bouncy press then release; a clean press is accepted 7 cycles after the
  // final low level is driven (2 sync + 4 samples + 1 press-to-strobe).
  task automatic do_press(input int bounces, input bit will_step);
    int c;
    for (int b = 0; b < bounces; b++) begin
      @(negedge clk); key_step_n = 1'b0;
      repeat (3) @(negedge clk);
      key_step_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    @(negedge clk);
    c = cyc;
    key_step_n = 1'b0;
    if (will_step) begin
      exp_q.push_back(c + 7);
      exp_count = exp_count + 16'd1;
    end
    repeat (20) @(negedge clk);
    key_step_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; key_step_n = 1'b1; run_sw = 1'b0; rate_sel = 2'b00;
    bp_en = 1'b0; bp_addr = 8'h00; pc = 32'h0;
    exp_count = 16'h0;
    #3;
    n_tests++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b, want 00", state); end
    n_tests++; if (cpu_ce !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ce: got %b, want 0", cpu_ce); end
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b, want 0", halted); end
    n_tests++; if (step_count !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %h, want 0000", step_count); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL reset_no_strobe: got %0d strobes, want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_press_debounce();
    int e, o;
    do_press(3, 1'b1);
    n_tests++; if (state !== 2'b00) begin n_fail++; $display("FAIL press_state: got %b, want 00", state); end
    n_tests++; if (step_count !== exp_count) begin n_fail++; $display("FAIL press_count_val: got %h, want %h", step_count, exp_count); end
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL press_strobes: got %0d, want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL press_cycle: strobe at %0d, want %0d", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // Rate 01 (period 16) for 100 cycles; a key press mid-run must be ignored
  task automatic test_run_rate();
    int c, d, e, o;
    @(negedge clk); c = cyc; run_sw = 1'b1; rate_sel = 2'b01;
    repeat (3) @(negedge clk);
    n_tests++; if (state !== 2'b01) begin n_fail++; $display("FAIL run_entry: got %b, want 01", state); end
    key_step_n = 1'b0;
    repeat (30) @(negedge clk);
    key_step_n = 1'b1;
    repeat (70) @(negedge clk);
    d = cyc; run_sw = 1'b0;
    push_run(c + 3 + 15, 16, d + 1);
    repeat (5) @(negedge clk);
    n_tests++; if (state !== 2'b00) begin n_fail++; $display("FAIL run_exit: got %b, want 00", state); end
    n_tests++; if (step_count !== exp_count) begin n_fail++; $display("FAIL run_count: got %h, want %h", step_count, exp_count); end
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL run_strobes: got %0d, want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL run_cycle: strobe at %0d, want %0d", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // Period 64 -> 16 with divider already past 15: wrap silently, then full 16
  task automatic test_rate_change();
    int c, en, e, o;
    @(negedge clk); c = cyc; run_sw = 1'b1; rate_sel = 2'b00;
    en = c + 3;
    repeat (33) @(negedge clk);
    rate_sel = 2'b01;
    repeat (30) @(negedge clk);
    run_sw = 1'b0;
    exp_q.push_back(en + 46);
    exp_count = exp_count + 16'd1;
    repeat (5) @(negedge clk);
    n_tests++; if (step_count !== exp_count) begin n_fail++; $display("FAIL ratechg_count: got %h, want %h", step_count, exp_count); end
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ratechg_strobes: got %0d, want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL ratechg_cycle: strobe at %0d, want %0d", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_breakpoint();
    int c, e, o;
    @(negedge clk);
    pc = 32'h0; bp_en = 1'b1; bp_addr = 8'h0C;
    @(negedge clk); c = cyc; run_sw = 1'b1; rate_sel = 2'b10;
`ifdef STEP_CTRL_BREAKPOINT_EN
    push_run(c + 6, 4, c + 14);
`else
    push_run(c + 6, 4, c + 18);
`endif
    repeat (19) @(negedge clk);
`ifdef STEP_CTRL_BREAKPOINT_EN
    n_tests++; if (state !== 2'b10) begin n_fail++; $display("FAIL bp_state: got %b, want 10", state); end
    n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL bp_halted: got %b, want 1", halted); end
    n_tests++; if (pc !== 32'h0C) begin n_fail++; $display("FAIL bp_pc: got %h, want 0000000c", pc); end
    do_press(0, 1'b1);
    n_tests++; if (state !== 2'b10) begin n_fail++; $display("FAIL halt_step_state: got %b, want 10", state); end
    n_tests++; if (pc !== 32'h10) begin n_fail++; $display("FAIL halt_step_pc: got %h, want 00000010", pc); end
`else
    n_tests++; if (state !== 2'b01) begin n_fail++; $display("FAIL nobp_state: got %b, want 01", state); end
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL nobp_halted: got %b, want 0", halted); end
    n_tests++; if (pc !== 32'h10) begin n_fail++; $display("FAIL nobp_pc: got %h, want 00000010", pc); end
`endif
    run_sw = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++; if (state !== 2'b00) begin n_fail++; $display("FAIL bp_exit_state: got %b, want 00", state); end
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL bp_exit_halted: got %b, want 0", halted); end
    n_tests++; if (step_count !== exp_count) begin n_fail++; $display("FAIL bp_count: got %h, want %h", step_count, exp_count); end
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_strobes: got %0d, want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL bp_cycle: strobe at %0d, want %0d", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    bp_en = 1'b0;
  endtask

  // Reset one cycle before a due strobe; run restarts with a full period
  task automatic test_reset_midrun();
    int c, r, d, e, o;
    @(negedge clk); c = cyc; run_sw = 1'b1; rate_sel = 2'b01;
    repeat (17) @(negedge clk);
    reset_n = 1'b0;
    exp_count = 16'h0;
    #1;
    n_tests++; if (state !== 2'b00) begin n_fail++; $display("FAIL rstrun_state: got %b, want 00", state); end
    n_tests++; if (cpu_ce !== 1'b0) begin n_fail++; $display("FAIL rstrun_cpu_ce: got %b, want 0", cpu_ce); end
    n_tests++; if (step_count !== 16'h0) begin n_fail++; $display("FAIL rstrun_count: got %h, want 0000", step_count); end
    @(negedge clk);
    n_tests++; if (cpu_ce !== 1'b0) begin n_fail++; $display("FAIL rstrun_due: got %b, want 0", cpu_ce); end
    r = cyc; reset_n = 1'b1;
    repeat (40) @(negedge clk);
    d = cyc; run_sw = 1'b0;
    push_run(r + 3 + 15, 16, d + 1);
    repeat (5) @(negedge clk);
    n_tests++; if (step_count !== exp_count) begin n_fail++; $display("FAIL rstrun_after: got %h, want %h", step_count, exp_count); end
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rstrun_strobes: got %0d, want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL rstrun_cycle: strobe at %0d, want %0d", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // Period 1 up to 0xFFFF, then one press wraps the count
  task automatic test_wrap();
    int c, d, e, o;
    @(negedge clk); c = cyc; run_sw = 1'b1; rate_sel = 2'b11;
    repeat (65536 - int'(exp_count)) @(negedge clk);
    d = cyc; run_sw = 1'b0;
    push_run(c + 3, 1, d + 1);
    repeat (5) @(negedge clk);
    n_tests++; if (step_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_full: got %h, want ffff", step_count); end
    do_press(0, 1'b1);
    n_tests++; if (step_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h, want 0000", step_count); end
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL wrap_strobes: got %0d, want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL wrap_cycle: strobe at %0d, want %0d", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    cyc = 0; n_tests = 0; n_fail = 0;
    test_reset();
    test_press_debounce();
    test_run_rate();
    test_rate_change();
    test_breakpoint();
    test_reset_midrun();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
